keypad_ctrl: RTL

Matrix-keypad input peripheral for the 4x4 hex keypad. It drives one column at a time and samples the rows, and it debounces each completed scan frame. Each new key press is pushed as a 4-bit code into a small first-word-fall-through FIFO that the CPU pops through the I/O bus. It is the input counterpart of the six-digit seven-segment display driver and sits beside it in the peripheral block.

---
 rtl/keypad_ctrl_pkg.sv | 43 ++++
 rtl/key_fifo.sv | 84 ++++++++
 rtl/keypad_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/keypad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// keypad_ctrl_pkg
//   Shared definitions for the 4x4 matrix-keypad peripheral.
//   - CODE_W    : width of a key code (row*4 + col)
//   - NUM_LINES : number of rows and of columns on the keypad
//   - CAND_W    : width of a debounce candidate, {valid, code}
//   - KEY_NONE  : candidate meaning "no single key pressed"
//   - snap_to_cand() : turns a 16-bit scan snapshot into a candidate
// -----------------------------------------------------------------------------
package keypad_ctrl_pkg;

    localparam int CODE_W    = 4;
    localparam int NUM_LINES = 4;
    localparam int SNAP_W    = NUM_LINES * NUM_LINES;
    localparam int CAND_W    = CODE_W + 1;

    localparam logic [CAND_W-1:0] KEY_NONE = '0;

    // Snapshot bit col*4+row holds the row line seen while that column was
    // driven. Exactly one set bit yields {1, row*4+col}; zero bits or several
    // bits (ghosting / multi-key) yield KEY_NONE.
    function automatic logic [CAND_W-1:0] snap_to_cand(
        input logic [SNAP_W-1:0] snap
    );
        logic [CAND_W-1:0] cand;
        int unsigned       hits;
        cand = KEY_NONE;
        hits = 0;
        for (int c = 0; c < NUM_LINES; c++) begin
            for (int r = 0; r < NUM_LINES; r++) begin
                if (snap[c*NUM_LINES + r]) begin
                    hits = hits + 1;
                    cand = {1'b1, CODE_W'(r*NUM_LINES + c)};
                end
            end
        end
        if (hits != 1) begin
            cand = KEY_NONE;
        end
        return cand;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
//   First-word-fall-through FIFO for key codes. The head entry is always
//   presented on head; a pop advances it on the same edge.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     push, din     : write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//     pop           : read request (ignored when empty)
//     head          : current oldest entry
//     count         : number of stored entries (0..DEPTH)
//     full, empty   : status decoded from count
// -----------------------------------------------------------------------------
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A full FIFO still accepts a write when a pop frees a slot that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/keypad_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_ctrl
//   4x4 matrix-keypad scanner with frame debounce and a key-code FIFO.
//   Ports:
//     Clock, Reset   : system clock, asynchronous active-high reset
//     Rows[3:0]      : raw row lines (active-high, asynchronous)
//     Columns[3:0]   : one-hot column drive
//     ReadEnable     : one-cycle pop request
//     ClearOverflow  : clears the sticky Overflow flag
//     KeyCode[3:0]   : FIFO head, code = row*4 + col
//     KeyValid       : FIFO not empty
//     KeyCount       : FIFO occupancy
//     Overflow       : sticky, set when a code is dropped on a full FIFO
// -----------------------------------------------------------------------------
module keypad_ctrl
    import keypad_ctrl_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_LINES-1:0]          Rows,
    output logic [NUM_LINES-1:0]          Columns,
    input  logic                          ReadEnable,
    input  logic                          ClearOverflow,
    output logic [CODE_W-1:0]             KeyCode,
    output logic                          KeyValid,
    output logic [$clog2(FIFO_DEPTH):0]   KeyCount,
    output logic                          Overflow
);

    localparam int DWELL_W = 16;
    localparam int STAB_W  = 4;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    // Synchronizer
    logic [NUM_LINES-1:0] rows_meta_q, rows_meta_d;
    logic [NUM_LINES-1:0] rows_sync_q, rows_sync_d;

    // Scan
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [1:0]           col_q, col_d;
    logic [SNAP_W-1:0]    snap_q, snap_d;

    // Debounce / report
    logic [CAND_W-1:0]    prev_cand_q, prev_cand_d;
    logic [STAB_W-1:0]    stable_q, stable_d;
    logic [CAND_W-1:0]    last_q, last_d;
    logic                 overflow_q, overflow_d;

    logic                 term_cnt;
    logic                 frame_end;
    logic [CAND_W-1:0]    cand;
    logic                 accept;
    logic                 push_req;
    logic                 pop_req;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [CODE_W-1:0]    fifo_head;

    assign term_cnt  = (dwell_q == DWELL_W'(SCAN_DIV - 1));
    assign frame_end = term_cnt && (col_q == 2'd3);
    assign pop_req   = ReadEnable && !fifo_empty;

    always_comb begin
        rows_meta_d = Rows;
        rows_sync_d = rows_meta_q;

        dwell_d = term_cnt ? '0 : dwell_q + DWELL_W'(1);
        col_d   = term_cnt ? col_q + 2'd1 : col_q;

        // Rows have settled for SCAN_DIV-1 cycles by the terminal count, which
        // covers the two synchronizer stages.
        snap_d = snap_q;
        if (term_cnt) begin
            snap_d[{col_q, 2'b00} +: NUM_LINES] = rows_sync_q;
        end

        // The candidate uses the snapshot including the column written this
        // cycle, so the frame is evaluated on its own final edge.
        cand = snap_to_cand(snap_d);

        prev_cand_d = prev_cand_q;
        stable_d    = stable_q;
        last_d      = last_q;
        accept      = 1'b0;
        push_req    = 1'b0;
        if (frame_end) begin
            prev_cand_d = cand;
            if (cand == prev_cand_q) begin
                stable_d = (stable_q == STAB_W'(DEBOUNCE)) ? stable_q
                                                          : stable_q + STAB_W'(1);
            end else begin
                stable_d = STAB_W'(1);
            end
            accept = (stable_d == STAB_W'(DEBOUNCE));
            if (accept) begin
                if (!cand[CAND_W-1]) begin
                    last_d = KEY_NONE;
                end else if (cand != last_q) begin
                    // last_reported follows the key even if the FIFO drops it,
                    // so a held key never retries.
                    push_req = 1'b1;
                    last_d   = cand;
                end
            end
        end

        // Set has priority over clear.
        overflow_d = overflow_q;
        if (ClearOverflow) begin
            overflow_d = 1'b0;
        end
        if (push_req && fifo_full && !pop_req) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rows_meta_q <= '0;
            rows_sync_q <= '0;
            dwell_q     <= '0;
            col_q       <= '0;
            snap_q      <= '0;
            prev_cand_q <= KEY_NONE;
            stable_q    <= '0;
            last_q      <= KEY_NONE;
            overflow_q  <= 1'b0;
        end else begin
            rows_meta_q <= rows_meta_d;
            rows_sync_q <= rows_sync_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            prev_cand_q <= prev_cand_d;
            stable_q    <= stable_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push_req),
        .pop   (pop_req),
        .din   (cand[CODE_W-1:0]),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign Columns  = NUM_LINES'(1) << col_q;
    assign KeyCode  = fifo_head;
    assign KeyValid = !fifo_empty;
    assign KeyCount = fifo_count;
    assign Overflow = overflow_q;

endmodule
